// File: rtl/intra_tbseq_pkg.sv
// intra_pkg: shared types and constants for the intra TB sequencer.
// Contents: component index encodings, phase enum, legal TB log2 range and
// a helper that clamps a requested TB log2 into that range.
package intra_pkg;

  localparam logic [1:0] CIDX_Y  = 2'd0;
  localparam logic [1:0] CIDX_CB = 2'd1;
  localparam logic [1:0] CIDX_CR = 2'd2;

  localparam logic [2:0] LOG2_MIN = 3'd2;
  localparam logic [2:0] LOG2_MAX = 3'd5;

  typedef enum logic [1:0] {
    PH_Y  = 2'd0,
    PH_CB = 2'd1,
    PH_CR = 2'd2
  } phase_e;

  // Out-of-range TB sizes are pinned to the nearest legal size
  function automatic logic [2:0] clampLog2(input logic [2:0] l);
    if (l < LOG2_MIN) return LOG2_MIN;
    if (l > LOG2_MAX) return LOG2_MAX;
    return l;
  endfunction

endpackage

// File: rtl/intra_tbseq_if.sv
// intra_tbseq_if: bundles the three TB request queues, the downstream stall
// and the per-cycle TB context produced by the sequencer.
// Modports: master = request/stall source and context sink (testbench side),
//           slave  = the sequencer itself.
// Optional macro INTRA_TBSEQ_MONO_EN adds the 'mono' request-side signal.
interface intra_tbseq_if #(
  parameter int unsigned CNT_W = 6
);
  logic             y_val;
  logic [2:0]       y_log2;
  logic             y_lastInCu;
  logic             y_in64;
  logic             y_rdy;
  logic             cb_val;
  logic [2:0]       cb_log2;
  logic             cb_lastInCu;
  logic             cb_rdy;
  logic             cr_val;
  logic [2:0]       cr_log2;
  logic             cr_lastInCu;
  logic             cr_rdy;
  logic             bStop;
  logic             tb_val;
  logic [1:0]       cIdx;
  logic [2:0]       tb_log2;
  logic [CNT_W-1:0] cycCnt;
  logic             isLastCycInTb;
  logic             isLast32In64_inter;
`ifdef INTRA_TBSEQ_MONO_EN
  logic             mono;
`endif

  modport master (
`ifdef INTRA_TBSEQ_MONO_EN
    output mono,
`endif
    output y_val, y_log2, y_lastInCu, y_in64,
    output cb_val, cb_log2, cb_lastInCu,
    output cr_val, cr_log2, cr_lastInCu,
    output bStop,
    input  y_rdy, cb_rdy, cr_rdy,
    input  tb_val, cIdx, tb_log2, cycCnt, isLastCycInTb, isLast32In64_inter
  );

  modport slave (
`ifdef INTRA_TBSEQ_MONO_EN
    input  mono,
`endif
    input  y_val, y_log2, y_lastInCu, y_in64,
    input  cb_val, cb_log2, cb_lastInCu,
    input  cr_val, cr_log2, cr_lastInCu,
    input  bStop,
    output y_rdy, cb_rdy, cr_rdy,
    output tb_val, cIdx, tb_log2, cycCnt, isLastCycInTb, isLast32In64_inter
  );

endinterface

// File: rtl/intra_tbseq_cyccnt.sv
// intra_tbCycCnt: cycle counter for the active TB.
// Ports: clk, rst (sync, active-high), load (new TB starts next cycle),
//        active (a TB is on the datapath), stall (hold), tbLog2 (size of the
//        active TB), cycCnt (cycle index), isLast (active and on final cycle).
module intra_tbCycCnt #(
  parameter int unsigned SPC_LOG2 = 4,
  parameter int unsigned CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             active,
  input  logic             stall,
  input  logic [2:0]       tbLog2,
  output logic [CNT_W-1:0] cycCnt,
  output logic             isLast
);

  logic [CNT_W-1:0] lastCnt;

  // nCyc-1 = 2^(2*log2 - SPC_LOG2) - 1, floored at 0 for TBs below one cycle
  always_comb begin
    int sh;
    sh      = 2 * int'(tbLog2) - int'(SPC_LOG2);
    lastCnt = '0;
    if (sh > 0) lastCnt = CNT_W'((32'd1 << sh) - 32'd1);
  end

  assign isLast = active && (cycCnt == lastCnt);

  // Restart on load or completion, otherwise advance on unstalled cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      cycCnt <= '0;
    end else if (load || (isLast && !stall)) begin
      cycCnt <= '0;
    end else if (active && !stall) begin
      cycCnt <= cycCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/intra_tbseq.sv
// intra_tbseq: transform-block sequencer in front of intra reconstruction.
// Serves luma, Cb and Cr TB queues in coding order (Y TBs of a CU, then Cb,
// then Cr), meters each TB over its cycle budget and emits the per-cycle TB
// context (cIdx, tb_log2, cycCnt, isLastCycInTb, isLast32In64_inter).
// Ports: clk, rst (sync, active-high), bus (intra_tbseq_if.slave).
// Optional macro INTRA_TBSEQ_MONO_EN: monochrome CUs skip the chroma phases.
module intra_tbseq
  import intra_pkg::*;
#(
  parameter int unsigned SPC_LOG2 = 4,
  parameter int unsigned CNT_W    = 6
) (
  input logic          clk,
  input logic          rst,
  intra_tbseq_if.slave bus
);

  phase_e     phase, phaseNxt;
  logic       tbVal;
  logic [1:0] cIdxQ;
  logic [2:0] log2Q;
  logic       lastInCuQ;
  logic       in64Q;
  logic [1:0] q64;
`ifdef INTRA_TBSEQ_MONO_EN
  logic       monoQ;
`endif

  logic       isLast, done, loadOk, load;
  logic       yRdy, cbRdy, crRdy;
  logic [1:0] selCidx;
  logic [2:0] selLog2;
  logic       selLast, selIn64;

  assign done = tbVal && isLast && !bus.bStop;

  // Phase state register
  always_ff @(posedge clk) begin
    if (rst) phase <= PH_Y;
    else     phase <= phaseNxt;
  end

  // Phase advances when the CU's last TB of the current component completes
  always_comb begin
    phaseNxt = phase;
    if (done && lastInCuQ) begin
      case (phase)
        PH_Y: begin
          phaseNxt = PH_CB;
`ifdef INTRA_TBSEQ_MONO_EN
          if (monoQ) phaseNxt = PH_Y;
`endif
        end
        PH_CB:   phaseNxt = PH_CR;
        PH_CR:   phaseNxt = PH_Y;
        default: phaseNxt = PH_Y;
      endcase
    end
  end

  // Load selection follows the post-completion phase so a CU boundary
  // costs no bubble cycle
  always_comb begin
    yRdy    = 1'b0;
    cbRdy   = 1'b0;
    crRdy   = 1'b0;
    selCidx = CIDX_Y;
    selLog2 = bus.y_log2;
    selLast = bus.y_lastInCu;
    selIn64 = bus.y_in64;
    loadOk  = !rst && !bus.bStop && (!tbVal || isLast);
    case (phaseNxt)
      PH_Y: yRdy = loadOk && bus.y_val;
      PH_CB: begin
        cbRdy   = loadOk && bus.cb_val;
        selCidx = CIDX_CB;
        selLog2 = bus.cb_log2;
        selLast = bus.cb_lastInCu;
        selIn64 = 1'b0;
      end
      PH_CR: begin
        crRdy   = loadOk && bus.cr_val;
        selCidx = CIDX_CR;
        selLog2 = bus.cr_log2;
        selLast = bus.cr_lastInCu;
        selIn64 = 1'b0;
      end
      default: ;
    endcase
  end

  assign load = yRdy || cbRdy || crRdy;

  // Active-TB context and 64x64 quadrant tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      tbVal     <= 1'b0;
      cIdxQ     <= CIDX_Y;
      log2Q     <= 3'd0;
      lastInCuQ <= 1'b0;
      in64Q     <= 1'b0;
      q64       <= 2'd0;
`ifdef INTRA_TBSEQ_MONO_EN
      monoQ     <= 1'b0;
`endif
    end else begin
      if (load) begin
        tbVal     <= 1'b1;
        cIdxQ     <= selCidx;
        log2Q     <= clampLog2(selLog2);
        lastInCuQ <= selLast;
        in64Q     <= selIn64;
      end else if (done) begin
        tbVal <= 1'b0;
      end
      if (done && (cIdxQ == CIDX_Y) && in64Q) q64 <= q64 + 2'd1;
`ifdef INTRA_TBSEQ_MONO_EN
      if (yRdy) monoQ <= bus.mono;
`endif
    end
  end

  intra_tbCycCnt #(
    .SPC_LOG2(SPC_LOG2),
    .CNT_W   (CNT_W)
  ) u_cycCnt (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .active(tbVal),
    .stall (bus.bStop),
    .tbLog2(log2Q),
    .cycCnt(bus.cycCnt),
    .isLast(isLast)
  );

  assign bus.y_rdy              = yRdy;
  assign bus.cb_rdy             = cbRdy;
  assign bus.cr_rdy             = crRdy;
  assign bus.tb_val             = tbVal;
  assign bus.cIdx               = cIdxQ;
  assign bus.tb_log2            = log2Q;
  assign bus.isLastCycInTb      = isLast;
  // Only luma quadrants 0..2 of a 64x64 CU are not the final 32x32 piece
  assign bus.isLast32In64_inter = !(tbVal && (cIdxQ == CIDX_Y) && in64Q && (q64 != 2'd3));

endmodule
